// File: rtl/fetch_prefetch_queue_if.sv
// Bundle of the memory fetch port, redirect request and instruction hand-off
// signals shared between the prefetch queue (master) and its environment (slave).
interface fetch_prefetch_queue_if;
    logic [31:0] memory_address1;
    logic [31:0] memory_data1;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output memory_address1,
        input  memory_data1,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        output instr_data,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  memory_address1,
        output memory_data1,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        input  instr_data,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: streams sequential word fetches ahead of the CPU,
// buffers up to DEPTH {pc,data} entries and flushes on a redirect.
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                    clk,
    input logic                    reset,
    fetch_prefetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          req_q, req_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [31:0]   entry_pc_q   [DEPTH];
    logic [31:0]   entry_pc_d   [DEPTH];
    logic [31:0]   entry_data_q [DEPTH];
    logic [31:0]   entry_data_d [DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic [CW:0]   credit;

    // An in-flight request already owns a slot, so it counts against the
    // free space before another fetch may be issued.
    always_comb begin
        credit       = {1'b0, count_q} + {{CW{1'b0}}, req_q};
        issue        = !bus.redirect_valid && (credit < (CW+1)'(DEPTH));
        push         = !bus.redirect_valid && req_q;
        pop          = !bus.redirect_valid && (count_q != '0) && bus.instr_ready;

        fetch_pc_d   = fetch_pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        req_d        = req_q;
        req_pc_d     = req_pc_q;
        entry_pc_d   = entry_pc_q;
        entry_data_d = entry_data_q;

        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            req_d      = 1'b0;
        end else begin
            if (issue) begin
                req_d      = 1'b1;
                req_pc_d   = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                req_d = 1'b0;
            end

            if (push) begin
                entry_pc_d[wr_ptr_q]   = req_pc_q;
                entry_data_d[wr_ptr_q] = bus.memory_data1;
                wr_ptr_d               = wr_ptr_q + 1'b1;
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end

            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            req_q      <= 1'b0;
            req_pc_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_pc_q[i]   <= '0;
                entry_data_q[i] <= '0;
            end
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            req_q        <= req_d;
            req_pc_q     <= req_pc_d;
            entry_pc_q   <= entry_pc_d;
            entry_data_q <= entry_data_d;
        end
    end

    // A response arriving into a full queue would mean the issue credit is broken.
    always @(posedge clk) begin
        if (!reset && push && !pop) begin
            assert (count_q < CW'(DEPTH));
        end
    end

    assign bus.memory_address1 = fetch_pc_q;
    assign bus.instr_valid     = (count_q != '0);
    assign bus.instr_data      = entry_data_q[rd_ptr_q];
    assign bus.instr_pc        = entry_pc_q[rd_ptr_q];
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: a fixed vector table, directed
// redirect/reset sequences and random traffic checked against a queue model.
module tb_fetch_prefetch_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    fetch_prefetch_queue_if bus();

    fetch_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h0000_1000 + {2'b00, addr[31:2]};
    endfunction

    // Synchronous memory: data for the address presented this cycle appears next cycle.
    always @(posedge clk) bus.memory_data1 <= mem_word(bus.memory_address1);

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] redir_pc;
        logic        ready;
        logic        exp_valid;
        logic        chk_head;
        logic [31:0] exp_pc;
        logic [31:0] exp_data;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic rst, input logic redir, input logic [31:0] rpc,
                                input logic ready, input logic ev, input logic ch,
                                input logic [31:0] epc, input logic [31:0] edata,
                                input logic [31:0] eaddr);
        vec_t v;
        v.rst = rst; v.redir = redir; v.redir_pc = rpc; v.ready = ready;
        v.exp_valid = ev; v.chk_head = ch; v.exp_pc = epc; v.exp_data = edata;
        v.exp_addr = eaddr;
        return v;
    endfunction

    task automatic apply_stimulus(input logic rst, input logic redir, input logic [31:0] rpc,
                                  input logic ready);
        reset              = rst;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.instr_ready    = ready;
    endtask

    // Reference model: the queue contents are just the PCs it holds (data is
    // a pure function of the PC), plus the PCs whose read is still in flight.
    logic [31:0] m_fetch_pc;
    logic [31:0] m_queue[$];
    logic [31:0] m_inflight[$];

    task automatic model_cycle();
        int          occupied;
        logic [31:0] resp_pc;
        logic        have_resp;
        occupied = m_queue.size() + m_inflight.size();
        if (reset) begin
            m_queue.delete();
            m_inflight.delete();
            m_fetch_pc = 32'h0;
        end else if (bus.redirect_valid) begin
            m_queue.delete();
            m_inflight.delete();
            m_fetch_pc = bus.redirect_pc & 32'hFFFF_FFFC;
        end else begin
            have_resp = (m_inflight.size() != 0);
            resp_pc   = 32'h0;
            if (have_resp) resp_pc = m_inflight.pop_front();
            if (m_queue.size() != 0 && bus.instr_ready) void'(m_queue.pop_front());
            if (have_resp) m_queue.push_back(resp_pc);
            if (occupied < DEPTH) begin
                m_inflight.push_back(m_fetch_pc);
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        check_output("mem_addr", bus.memory_address1, m_fetch_pc);
        check_output("instr_valid", {31'b0, bus.instr_valid}, {31'b0, m_queue.size() != 0});
        if (m_queue.size() != 0) begin
            check_output("instr_pc", bus.instr_pc, m_queue[0]);
            check_output("instr_data", bus.instr_data, mem_word(m_queue[0]));
        end
    endtask

    initial begin
        logic [31:0] wrap_pcs[3];
        wrap_pcs[0] = 32'hFFFF_FFF8;
        wrap_pcs[1] = 32'hFFFF_FFFC;
        wrap_pcs[2] = 32'h0000_0000;

        //          rst redir rpc          rdy ev ch  pc           data         addr
        vecs[0]  = mk(1, 0, 32'h0,        0,  0, 1, 32'h0,       32'h0,       32'h00);
        vecs[1]  = mk(0, 0, 32'h0,        0,  0, 1, 32'h0,       32'h0,       32'h04);
        vecs[2]  = mk(0, 0, 32'h0,        0,  1, 1, 32'h0,       32'h1000,    32'h08);
        vecs[3]  = mk(0, 0, 32'h0,        0,  1, 1, 32'h0,       32'h1000,    32'h0C);
        vecs[4]  = mk(0, 0, 32'h0,        0,  1, 1, 32'h0,       32'h1000,    32'h10);
        vecs[5]  = mk(0, 0, 32'h0,        0,  1, 1, 32'h0,       32'h1000,    32'h10);
        vecs[6]  = mk(0, 0, 32'h0,        0,  1, 1, 32'h0,       32'h1000,    32'h10);
        vecs[7]  = mk(0, 0, 32'h0,        0,  1, 1, 32'h0,       32'h1000,    32'h10);
        vecs[8]  = mk(0, 0, 32'h0,        1,  1, 1, 32'h4,       32'h1001,    32'h10);
        vecs[9]  = mk(0, 0, 32'h0,        1,  1, 1, 32'h8,       32'h1002,    32'h14);
        vecs[10] = mk(0, 0, 32'h0,        1,  1, 1, 32'hC,       32'h1003,    32'h18);
        vecs[11] = mk(0, 0, 32'h0,        1,  1, 1, 32'h10,      32'h1004,    32'h1C);
        vecs[12] = mk(0, 0, 32'h0,        1,  1, 1, 32'h14,      32'h1005,    32'h20);
        vecs[13] = mk(0, 1, 32'h43,       1,  0, 0, 32'h0,       32'h0,       32'h40);
        vecs[14] = mk(0, 0, 32'h0,        1,  0, 0, 32'h0,       32'h0,       32'h44);
        vecs[15] = mk(0, 0, 32'h0,        1,  1, 1, 32'h40,      32'h1010,    32'h48);
        vecs[16] = mk(0, 0, 32'h0,        1,  1, 1, 32'h44,      32'h1011,    32'h4C);

        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].redir, vecs[i].redir_pc, vecs[i].ready);
            @(posedge clk);
            #1;
            check_output($sformatf("vec%0d_addr", i), bus.memory_address1, vecs[i].exp_addr);
            check_output($sformatf("vec%0d_valid", i), {31'b0, bus.instr_valid},
                         {31'b0, vecs[i].exp_valid});
            if (vecs[i].chk_head) begin
                check_output($sformatf("vec%0d_pc", i), bus.instr_pc, vecs[i].exp_pc);
                check_output($sformatf("vec%0d_data", i), bus.instr_data, vecs[i].exp_data);
            end
        end

        // Redirect while three entries are queued and a read is in flight.
        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0);
        model_cycle();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
            model_cycle();
        end
        apply_stimulus(1'b0, 1'b1, 32'h40, 1'b1);
        model_cycle();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
            model_cycle();
        end

        // Redirect near the top of the address space: fetch PC wraps to zero.
        apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        model_cycle();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        model_cycle();
        for (int i = 0; i < 3; i++) begin
            model_cycle();
            check_output($sformatf("wrap_pc%0d", i), bus.instr_pc, wrap_pcs[i]);
        end

        // Reset together with a redirect: reset must win.
        apply_stimulus(1'b1, 1'b1, 32'h80, 1'b1);
        model_cycle();

        for (int i = 0; i < 1000; i++) begin
            apply_stimulus(1'b0, ($urandom_range(0, 49) == 0), $urandom,
                           logic'($urandom_range(0, 1)));
            model_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
